// File: rtl/fp32_arb_pkg.sv
// Shared constants, types and helpers for the fp32 multiplier arbiter.
// Pipeline control travels as one packed struct so every stage carries the same fields.
package fp32_arb_pkg;
  localparam int FP32_WIDTH  = 32;
  localparam int NUM_REQ_DEF = 4;
  localparam int MAX_REQ     = 8;
  localparam int MAX_ID_W    = 3;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

  typedef struct packed {
    logic        vld;
    logic        sign;
    logic        spec;
    logic [31:0] spec_val;
    logic [9:0]  exp;
  } mul_ctl_t;

  function automatic logic [MAX_ID_W-1:0] onehot_to_id(input logic [MAX_REQ-1:0] oh);
    logic [MAX_ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) id = id | MAX_ID_W'(i);
    return id;
  endfunction
endpackage

// File: rtl/fp32_mul.sv
// Five-stage fp32 multiplier, round-to-nearest-even, subnormals flushed to zero.
// Latency 5 cycles valid_in -> valid_out, one op per cycle, no backpressure.
module fp32_mul
  import fp32_arb_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  input  logic [FP32_WIDTH-1:0] a_in,
  input  logic [FP32_WIDTH-1:0] b_in,
  output logic                  valid_out,
  output logic [FP32_WIDTH-1:0] c_out
);
  logic        w_sign, w_za, w_zb, w_ia, w_ib, w_na, w_nb;
  mul_ctl_t    w_ctl0, r_ctl1, r_ctl2, r_ctl3, r_ctl4;
  logic [23:0] r_ma, r_mb, r_mant3, w_mant3;
  logic [47:0] r_prod;
  logic        r_guard, r_sticky, w_guard, w_sticky;
  logic [9:0]  w_exp3, w_exp4;
  logic [24:0] w_rnd;
  logic [22:0] r_frac4, w_frac4;
  logic [31:0] w_pack;

  assign w_sign = a_in[31] ^ b_in[31];
  assign w_za   = (a_in[30:23] == 8'd0);
  assign w_zb   = (b_in[30:23] == 8'd0);
  assign w_ia   = (a_in[30:23] == 8'hFF) && (a_in[22:0] == 23'd0);
  assign w_ib   = (b_in[30:23] == 8'hFF) && (b_in[22:0] == 23'd0);
  assign w_na   = (a_in[30:23] == 8'hFF) && (a_in[22:0] != 23'd0);
  assign w_nb   = (b_in[30:23] == 8'hFF) && (b_in[22:0] != 23'd0);

  // Specials resolved up front; they bypass the datapath in the control struct.
  always_comb begin
    w_ctl0          = '0;
    w_ctl0.vld      = valid_in;
    w_ctl0.sign     = w_sign;
    w_ctl0.exp      = {2'b00, a_in[30:23]} + {2'b00, b_in[30:23]} - 10'd127;
    w_ctl0.spec     = 1'b1;
    if (w_na || w_nb || (w_ia && w_zb) || (w_za && w_ib)) w_ctl0.spec_val = 32'h7FC0_0000;
    else if (w_ia || w_ib)                                w_ctl0.spec_val = {w_sign, 8'hFF, 23'd0};
    else if (w_za || w_zb)                                w_ctl0.spec_val = {w_sign, 31'd0};
    else                                                  w_ctl0.spec     = 1'b0;
  end

  always_comb begin
    w_exp3 = r_ctl2.exp;
    if (r_prod[47]) begin
      w_mant3  = r_prod[47:24];
      w_guard  = r_prod[23];
      w_sticky = |r_prod[22:0];
      w_exp3   = r_ctl2.exp + 10'd1;
    end else begin
      w_mant3  = r_prod[46:23];
      w_guard  = r_prod[22];
      w_sticky = |r_prod[21:0];
    end
  end

  always_comb begin
    w_rnd   = {1'b0, r_mant3} + 25'(r_guard & (r_sticky | r_mant3[0]));
    w_exp4  = w_rnd[24] ? r_ctl3.exp + 10'd1 : r_ctl3.exp;
    w_frac4 = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
  end

  // Exponent is two's complement here: overflow saturates to inf, underflow flushes to zero.
  always_comb begin
    if (r_ctl4.spec)                        w_pack = r_ctl4.spec_val;
    else if ($signed(r_ctl4.exp) >= 10'sd255) w_pack = {r_ctl4.sign, 8'hFF, 23'd0};
    else if ($signed(r_ctl4.exp) <= 10'sd0)   w_pack = {r_ctl4.sign, 31'd0};
    else                                    w_pack = {r_ctl4.sign, r_ctl4.exp[7:0], r_frac4};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ctl1 <= '0; r_ctl2 <= '0; r_ctl3 <= '0; r_ctl4 <= '0;
      r_ma <= '0; r_mb <= '0; r_prod <= '0;
      r_mant3 <= '0; r_guard <= 1'b0; r_sticky <= 1'b0; r_frac4 <= '0;
      valid_out <= 1'b0; c_out <= '0;
    end else begin
      r_ctl1   <= w_ctl0;
      r_ma     <= {1'b1, a_in[22:0]};
      r_mb     <= {1'b1, b_in[22:0]};
      r_ctl2   <= r_ctl1;
      r_prod   <= 48'(r_ma) * 48'(r_mb);
      r_ctl3   <= r_ctl2;
      r_ctl3.exp <= w_exp3;
      r_mant3  <= w_mant3;
      r_guard  <= w_guard;
      r_sticky <= w_sticky;
      r_ctl4   <= r_ctl3;
      r_ctl4.exp <= w_exp4;
      r_frac4  <= w_frac4;
      valid_out <= r_ctl4.vld;
      c_out    <= w_pack;
    end
  end
endmodule

// File: rtl/pipe.sv
// Fixed-depth valid/data delay line: DEPTH cycles, no backpressure, cleared by reset.
module pipe #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);
  logic [DEPTH-1:0] r_vld;
  logic [W-1:0]     r_dat [DEPTH];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_dat[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_dat = r_dat[DEPTH-1];
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from rr_ptr upward, pointer moves past the winner.
module rr_arbiter
  import fp32_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [N-1:0] req_in,
  input  logic         advance_in,
  output logic [N-1:0] grant_out
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW:0]   w_idx;
  logic          w_found;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_next;

  always_comb begin
    grant_out = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(N)) w_idx = w_idx - (PW+1)'(N);
      if (!w_found && req_in[w_idx[PW-1:0]]) begin
        grant_out[w_idx[PW-1:0]] = 1'b1;
        w_found = 1'b1;
      end
    end
  end

  assign w_win  = PW'(onehot_to_id(MAX_REQ'(grant_out)));
  assign w_next = (w_win == PW'(N-1)) ? '0 : w_win + PW'(1);

  always_ff @(posedge clk_in) begin
    if (rst_in)          r_ptr <= '0;
    else if (advance_in) r_ptr <= w_next;
  end
endmodule

// File: rtl/fp32_mul_arbiter.sv
// Shares one pipelined fp32_mul among NUM_REQ requesters; results MUL_LATENCY cycles after fire.
// No result backpressure. Optional grant counters under FP32_MUL_ARB_STATS_EN.
module fp32_mul_arbiter
  import fp32_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 5
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*FP32_WIDTH-1:0] req_a_in,
  input  logic [NUM_REQ*FP32_WIDTH-1:0] req_b_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [NUM_REQ-1:0]            res_valid_out,
  output logic [$clog2(NUM_REQ)-1:0]    res_id_out,
  output logic [FP32_WIDTH-1:0]         res_c_out,
  output logic                          busy_out
`ifdef FP32_MUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         stat_grants_out,
  input  logic                          stat_clr_in
`endif
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MUL_LATENCY + 1);

  logic [NUM_REQ-1:0]    w_grant, w_fire;
  logic                  w_issue, w_mul_vld, w_tag_vld, w_res;
  logic [IDW-1:0]        w_gid, w_tag_id;
  logic [FP32_WIDTH-1:0] w_a, w_b, w_c;
  logic [CW-1:0]         r_inflight;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .req_in     (req_valid_in),
    .advance_in (w_issue),
    .grant_out  (w_grant)
  );

  assign req_ready_out = rst_in ? '0 : w_grant;
  assign w_fire        = req_valid_in & req_ready_out;
  assign w_issue       = |w_fire;
  assign w_gid         = IDW'(onehot_to_id(MAX_REQ'(w_fire)));

  // Only the fired slice reaches the multiplier, so idle requesters' operands never leak in.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_fire[i]) begin
        w_a = req_a_in[i*FP32_WIDTH +: FP32_WIDTH];
        w_b = req_b_in[i*FP32_WIDTH +: FP32_WIDTH];
      end
    end
  end

  // fp32_mul has a fixed 5-stage pipe; MUL_LATENCY must stay equal to it.
  fp32_mul u_mul (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .valid_in  (w_issue),
    .a_in      (w_a),
    .b_in      (w_b),
    .valid_out (w_mul_vld),
    .c_out     (w_c)
  );

  pipe #(.W(IDW), .DEPTH(MUL_LATENCY)) u_tag (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_vld  (w_issue),
    .i_dat  (w_gid),
    .o_vld  (w_tag_vld),
    .o_dat  (w_tag_id)
  );

  assign w_res = w_mul_vld & w_tag_vld;

  always_comb begin
    res_valid_out = '0;
    for (int i = 0; i < NUM_REQ; i++)
      res_valid_out[i] = w_res & (w_tag_id == IDW'(i));
  end

  assign res_id_out = w_tag_id;
  assign res_c_out  = w_c;
  assign busy_out   = (r_inflight != '0);

  always_ff @(posedge clk_in) begin
    if (rst_in)                 r_inflight <= '0;
    else if (w_issue && !w_res) r_inflight <= r_inflight + CW'(1);
    else if (!w_issue && w_res) r_inflight <= r_inflight - CW'(1);
  end

  a_inflight_bound: assert property (@(posedge clk_in) disable iff (rst_in)
    r_inflight <= CW'(MUL_LATENCY));

`ifdef FP32_MUL_ARB_STATS_EN
  logic [15:0] r_grants [NUM_REQ];

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst_in || stat_clr_in)                   r_grants[i] <= '0;
      else if (w_fire[i] && r_grants[i] != 16'hFFFF) r_grants[i] <= r_grants[i] + 16'd1;
    end
  end

  always_comb begin
    stat_grants_out = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grants_out[i*16 +: 16] = r_grants[i];
  end
`endif
endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Bench for fp32_mul_arbiter: per-cycle scoreboard of grants, results and busy.
module tb_fp32_mul_arbiter;
  import fp32_arb_pkg::*;

  localparam int NR  = 4;
  localparam int LAT = 5;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic [NR-1:0]     req_valid_in = '0;
  logic [NR*32-1:0]  req_a_in = '0;
  logic [NR*32-1:0]  req_b_in = '0;
  logic [NR-1:0]     req_ready_out, res_valid_out;
  logic [1:0]        res_id_out;
  logic [31:0]       res_c_out;
  logic              busy_out;
`ifdef FP32_MUL_ARB_STATS_EN
  logic [NR*16-1:0]  stat_grants_out;
  logic              stat_clr_in = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  fp32_mul_arbiter #(.NUM_REQ(NR), .MUL_LATENCY(LAT)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_a_in      (req_a_in),
    .req_b_in      (req_b_in),
    .req_ready_out (req_ready_out),
    .res_valid_out (res_valid_out),
    .res_id_out    (res_id_out),
    .res_c_out     (res_c_out),
    .busy_out      (busy_out)
`ifdef FP32_MUL_ARB_STATS_EN
    ,
    .stat_grants_out (stat_grants_out),
    .stat_clr_in     (stat_clr_in)
`endif
  );

  typedef struct { int due; int id; logic [31:0] c; } exp_t;
  typedef struct { int cyc; int id; logic [31:0] c; } obs_t;

  exp_t        exp_q[$];
  obs_t        log_q[$];
  int          dut_gnt_q[$];
  int          dut_gcnt[NR];
  int          ptr, cyc, n_checks, n_fail;
  logic [31:0] opa[NR], opb[NR];

  // Exact product in double (48 significant bits fit), then one RNE rounding to fp32.
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    real         ra, rb;
    logic [63:0] d;
    int          e;
    logic [23:0] m;
    logic [24:0] r;
    ra = $bitstoreal({a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'd0});
    rb = $bitstoreal({b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'd0});
    d  = $realtobits(ra * rb);
    e  = int'(d[62:52]) - 896;
    m  = {1'b1, d[51:29]};
    r  = {1'b0, m} + 25'(d[28] && ((|d[27:0]) || m[0]));
    if (r[24]) begin
      e = e + 1;
      r = r >> 1;
    end
    return {d[63], 8'(e), r[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic step(input logic rst, input logic [NR-1:0] vld);
    logic [NR-1:0] exp_grant;
    logic [NR-1:0] exp_vld;
    int gid;
    exp_t e;
    @(negedge clk_in);
    rst_in       = rst;
    req_valid_in = vld;
    for (int i = 0; i < NR; i++) begin
      req_a_in[i*32 +: 32] = vld[i] ? opa[i] : $urandom();
      req_b_in[i*32 +: 32] = vld[i] ? opb[i] : $urandom();
    end
    #1;
    exp_grant = '0;
    gid = -1;
    if (!rst)
      for (int k = 0; k < NR; k++) begin
        int idx = (ptr + k) % NR;
        if (gid < 0 && vld[idx]) gid = idx;
      end
    if (gid >= 0) exp_grant[gid] = 1'b1;
    n_checks++;
    if (req_ready_out !== exp_grant) begin
      n_fail++;
      $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, req_ready_out, exp_grant);
    end
    for (int i = 0; i < NR; i++)
      if (req_ready_out[i] && vld[i]) begin
        dut_gnt_q.push_back(i);
        dut_gcnt[i]++;
      end
    n_checks++;
    if (busy_out !== (exp_q.size() != 0)) begin
      n_fail++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_out, exp_q.size() != 0);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      exp_vld = NR'(1 << e.id);
      n_checks++;
      if (res_valid_out !== exp_vld) begin
        n_fail++;
        $display("FAIL res_valid cyc=%0d got=%b exp=%b", cyc, res_valid_out, exp_vld);
      end
      n_checks++;
      if (res_id_out !== 2'(e.id)) begin
        n_fail++;
        $display("FAIL res_id cyc=%0d got=%0d exp=%0d", cyc, res_id_out, e.id);
      end
      n_checks++;
      if (res_c_out !== e.c) begin
        n_fail++;
        $display("FAIL res_c cyc=%0d got=%h exp=%h", cyc, res_c_out, e.c);
      end
      log_q.push_back('{cyc, int'(res_id_out), res_c_out});
    end else begin
      n_checks++;
      if (res_valid_out !== '0) begin
        n_fail++;
        $display("FAIL res_spurious cyc=%0d got=%b exp=0", cyc, res_valid_out);
      end
    end
    if (gid >= 0) begin
      exp_q.push_back('{cyc + LAT, gid, fmul_ref(opa[gid], opb[gid])});
      ptr = (gid + 1) % NR;
    end
    if (rst) begin
      exp_q.delete();
      ptr = 0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic test_reset();
    step(1'b1, '1);
    step(1'b1, '1);
    n_checks++;
    if (res_c_out !== 32'd0 || res_id_out !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_res got c=%h id=%0d exp c=0 id=0", res_c_out, res_id_out);
    end
    n_checks++;
    if (busy_out !== 1'b0 || req_ready_out !== '0) begin
      n_fail++;
      $display("FAIL reset_ctl got busy=%b ready=%b exp 0/0", busy_out, req_ready_out);
    end
  endtask

  task automatic test_single();
    int fc, base;
    base = log_q.size();
    opa[0] = 32'h43970FFD; opb[0] = 32'h40C91759;
    fc = cyc;
    step(1'b0, 4'b0001);
    idle(LAT + 2);
    n_checks++;
    if (log_q.size() != base + 1 || log_q[base].c !== 32'h44ED52A9 || log_q[base].cyc != fc + LAT) begin
      n_fail++;
      $display("FAIL single got n=%0d c=%h cyc=%0d exp n=%0d c=44ed52a9 cyc=%0d",
               log_q.size() - base, log_q[base].c, log_q[base].cyc, 1, fc + LAT);
    end
  endtask

  task automatic test_all_four();
    logic [31:0] exp_c[4] = '{32'h44ED52A9, 32'h3E243BBA, 32'hC2AEA9B3, 32'hBC3D25F0};
    int fc, base, gbase;
    step(1'b1, '0);
    opa = '{32'h43970FFD, 32'h3DFFCB92, 32'hC141BE77, 32'h3DE31F8A};
    opb = '{32'h40C91759, 32'h3FA45D64, 32'h40E6C99B, 32'hBDD53261};
    base = log_q.size(); gbase = dut_gnt_q.size(); fc = cyc;
    step(1'b0, 4'b1111); step(1'b0, 4'b1110); step(1'b0, 4'b1100); step(1'b0, 4'b1000);
    idle(LAT + 2);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (dut_gnt_q[gbase + k] != k || log_q[base + k].id != k || log_q[base + k].c !== exp_c[k]
          || log_q[base + k].cyc != fc + LAT + k) begin
        n_fail++;
        $display("FAIL four_%0d got gnt=%0d id=%0d c=%h cyc=%0d exp gnt=%0d id=%0d c=%h cyc=%0d", k,
                 dut_gnt_q[gbase + k], log_q[base + k].id, log_q[base + k].c, log_q[base + k].cyc,
                 k, k, exp_c[k], fc + LAT + k);
      end
    end
  endtask

  task automatic test_rr_skip();
    int base;
    for (int i = 0; i < NR; i++) begin opa[i] = rand_fp(); opb[i] = rand_fp(); end
    base = log_q.size();
    step(1'b0, 4'b0100);
    step(1'b0, 4'b1010);
    step(1'b0, 4'b1010);
    idle(LAT + 2);
    n_checks++;
    if (log_q.size() != base + 3 || log_q[base].id != 2 || log_q[base+1].id != 3 || log_q[base+2].id != 1) begin
      n_fail++;
      $display("FAIL rr_skip got ids %0d,%0d,%0d exp 2,3,1",
               log_q[base].id, log_q[base+1].id, log_q[base+2].id);
    end
  endtask

  task automatic test_reset_midop();
    int base;
    base = log_q.size();
    step(1'b0, '1); step(1'b0, '1); step(1'b0, '1);
    step(1'b1, '0);
    idle(LAT + 5);
    n_checks++;
    if (log_q.size() != base || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop got results=%0d busy=%b exp 0/0", log_q.size() - base, busy_out);
    end
  endtask

  task automatic test_fairness();
    for (int i = 0; i < NR; i++) dut_gcnt[i] = 0;
`ifdef FP32_MUL_ARB_STATS_EN
    stat_clr_in = 1'b1;
    step(1'b0, '0);
    stat_clr_in = 1'b0;
`endif
    for (int c = 0; c < 40; c++) step(1'b0, '1);
    idle(LAT + 2);
    for (int i = 0; i < NR; i++) begin
      n_checks++;
      if (dut_gcnt[i] != 10) begin
        n_fail++;
        $display("FAIL fair_%0d got=%0d exp=10", i, dut_gcnt[i]);
      end
`ifdef FP32_MUL_ARB_STATS_EN
      n_checks++;
      if (stat_grants_out[i*16 +: 16] !== 16'd10) begin
        n_fail++;
        $display("FAIL stat_%0d got=%0d exp=10", i, stat_grants_out[i*16 +: 16]);
      end
`endif
    end
`ifdef FP32_MUL_ARB_STATS_EN
    stat_clr_in = 1'b1;
    step(1'b0, '0);
    stat_clr_in = 1'b0;
    step(1'b0, '0);
    n_checks++;
    if (stat_grants_out !== '0) begin
      n_fail++;
      $display("FAIL stat_clr got=%h exp=0", stat_grants_out);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int base;
    base = log_q.size();
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < NR; i++) begin opa[i] = rand_fp(); opb[i] = rand_fp(); end
      step(1'b0, '1);
    end
    idle(LAT + 2);
    n_checks++;
    if (log_q.size() != base + 15 || log_q[base + 14].cyc != log_q[base].cyc + 14 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b got n=%0d span=%0d busy=%b exp n=15 span=14 busy=0", log_q.size() - base,
               log_q[base + 14].cyc - log_q[base].cyc, busy_out);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NR; i++) begin opa[i] = rand_fp(); opb[i] = rand_fp(); end
      step(1'b0, NR'($urandom_range(0, 15)));
    end
    idle(LAT + 2);
  endtask

  initial begin
    ptr = 0; cyc = 0; n_checks = 0; n_fail = 0;
    for (int i = 0; i < NR; i++) begin opa[i] = '0; opb[i] = '0; dut_gcnt[i] = 0; end
    test_reset();
    test_single();
    test_all_four();
    test_rr_skip();
    test_reset_midop();
    test_fairness();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
